spi_slave_core: RTL and testbench

Parametrised SPI slave running entirely in the system clock domain. SCLK, CS and MOSI are oversampled through synchronisers. The block supports all four SPI modes (CPOL/CPHA), a configurable word width and back-to-back words within one CS assertion. A valid/ready TX buffer on the fabric side supplies MISO data, and a one-cycle RX strobe delivers each received word. It sits between the board-level SPI pins and the register/command logic.

---
 rtl/spi_slave_core.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave (all four modes) oversampled in the system clock domain
//
// Purpose: receives MSB-first words from an SPI master and returns words
// supplied through a one-entry valid/ready TX buffer. sclk, cs and mosi are
// synchronised into clk, so the whole block runs on the posedge of clk.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   cs, sclk, mosi        SPI pins from the master (cs active-low)
//   miso                  slave data to the master, 0 while deselected
//   tx_data/valid/ready   fabric-side TX buffer (ready = buffer empty)
//   rx_data, rx_valid     last complete received word and its 1-cycle strobe
//   busy                  transfer in progress (synchronised cs asserted)
//   tx_underrun           1-cycle strobe, a word began with the TX buffer empty

module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SYNC_STAGES:0]   fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   ur_pend_q, ur_pend_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              cs_fall, cs_rise, flushed, load;
  logic [DATA_W-1:0] rx_word;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    fill_d        = {fill_q[SYNC_STAGES-1:0], 1'b1};
    sclk_s        = sclk_sync_q[SYNC_STAGES-1];
    cs_s          = cs_sync_q[SYNC_STAGES-1];
    mosi_s        = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d   = sclk_s;
    cs_prev_d     = cs_s;

    lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
    trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;

    // Synchroniser flops are preset to the idle levels, so right after reset
    // they do not yet reflect the pins. A transfer may only start once the
    // flushed pipeline has shown cs high; a cs held low across reset is ignored.
    flushed = fill_q[SYNC_STAGES];
    armed_d = armed_q | (flushed & cs_s);
    cs_fall = armed_q && cs_prev_q && !cs_s;
    cs_rise = !cs_prev_q && cs_s;

    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    rx_sh_d       = rx_sh_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    tx_underrun_d = 1'b0;
    ur_pend_d     = ur_pend_q;
    rx_word       = {rx_sh_q[DATA_W-2:0], mosi_s};
    load          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          cnt_d     = '0;
          rx_sh_d   = '0;
          ur_pend_d = 1'b0;
          load      = !CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          rx_sh_d   = '0;
          ur_pend_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sh_d = rx_word;
            // With CPHA=0 the load happens at the end of the previous word;
            // an empty-buffer load is only reported once the next word starts.
            if (cnt_q == '0 && ur_pend_q) begin
              tx_underrun_d = 1'b1;
              ur_pend_d     = 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              load       = !CPHA;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (shift_edge) begin
            if (CPHA && cnt_q == '0) begin
              load = 1'b1;
            end else if (CPHA || cnt_q != '0) begin
              // CPHA=0: the shift edge right after a word boundary is skipped
              // so the freshly loaded MSB stays on miso.
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (tx_ready_q) begin
        shreg_d = '0;
        if (CPHA) tx_underrun_d = 1'b1;
        else      ur_pend_d     = 1'b1;
      end else begin
        shreg_d    = tx_buf_q;
        tx_ready_d = 1'b1;
      end
    end

    // Accept after load so a simultaneous load takes the old word.
    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    miso_d = (state_d == ST_ACTIVE) ? shreg_q[DATA_W-1] : 1'b0;
    busy_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sclk_sync_q   <= {SYNC_STAGES{CPOL}};
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= CPOL;
      cs_prev_q     <= 1'b1;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
      shreg_q       <= '0;
      rx_sh_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      ur_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      rx_sh_q       <= rx_sh_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      ur_pend_q     <= ur_pend_d;
      miso_q        <= miso_d;
      busy_q        <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed self-checking bench for spi_slave_core
//
// Instances 0..3: DATA_W=16 in SPI modes 0..3. Instance 4: DATA_W=8, mode 0.

module tb_spi_slave_core;

  localparam int HALF = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cs = 5'b11111;
  logic [4:0]  sclk = 5'b01100;
  logic [4:0]  tx_valid = 5'b00000;
  logic        mosi = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  wire  [4:0]  miso, tx_ready, rx_valid, busy, tx_underrun;
  logic [15:0] rx16 [4];
  logic [7:0]  rx8;

  int          n_checks = 0;
  int          n_fail = 0;
  int          rx_cnt [5] = '{default: 0};
  int          ur_cnt [5] = '{default: 0};
  logic [15:0] rx_log [5][8];
  logic [15:0] mo_words [4];
  logic [15:0] mi_words [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_m16
    spi_slave_core #(.DATA_W(16), .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .cs(cs[g]), .sclk(sclk[g]), .mosi(mosi), .miso(miso[g]),
      .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx16[g]), .rx_valid(rx_valid[g]), .busy(busy[g]), .tx_underrun(tx_underrun[g]));
  end

  spi_slave_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .cs(cs[4]), .sclk(sclk[4]), .mosi(mosi), .miso(miso[4]),
    .tx_data(tx_data[7:0]), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
    .rx_data(rx8), .rx_valid(rx_valid[4]), .busy(busy[4]), .tx_underrun(tx_underrun[4]));

  function automatic bit cpol_of(input int idx);
    return (idx == 2) || (idx == 3);
  endfunction

  function automatic bit cpha_of(input int idx);
    return (idx == 1) || (idx == 3);
  endfunction

  function automatic int width_of(input int idx);
    return (idx == 4) ? 8 : 16;
  endfunction

  function automatic logic [15:0] rxd(input int idx);
    if (idx == 4) return {8'h00, rx8};
    return rx16[idx];
  endfunction

  // Every cycle of rx_valid counts as a word, so a stretched strobe shows up as extra words.
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (rx_valid[k] === 1'b1) begin
        rx_log[k][rx_cnt[k] % 8] <= rxd(k);
        rx_cnt[k] <= rx_cnt[k] + 1;
      end
      if (tx_underrun[k] === 1'b1) ur_cnt[k] <= ur_cnt[k] + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tx_push(input int idx, input logic [15:0] d);
    int t = 0;
    while (tx_ready[idx] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (tx_ready[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_push_wait idx=%0d tx_ready=%b required 1", idx, tx_ready[idx]);
    end else begin
      tx_data = d;
      tx_valid[idx] = 1'b1;
      @(negedge clk);
      tx_valid[idx] = 1'b0;
    end
  endtask

  // Master: sends mo_words MSB first, captures miso into mi_words.
  task automatic spi_frame(input int idx, input int nwords, input int stop_bits, input bit raise_cs);
    int w, total, wi, bi;
    bit pol, pha;
    w = width_of(idx);
    pol = cpol_of(idx);
    pha = cpha_of(idx);
    total = (stop_bits > 0) ? stop_bits : nwords * w;
    for (int i = 0; i < 4; i++) mi_words[i] = 16'h0000;
    cs[idx] = 1'b0;
    if (!pha) mosi = mo_words[0][w-1];
    for (int b = 0; b < total; b++) begin
      wi = b / w;
      bi = w - 1 - (b % w);
      if (!pha) begin
        if (b > 0) mosi = mo_words[wi][bi];
        repeat (HALF) @(negedge clk);
        sclk[idx] = ~pol;
        mi_words[wi][bi] = miso[idx];
        repeat (HALF) @(negedge clk);
        sclk[idx] = pol;
      end else begin
        repeat (HALF) @(negedge clk);
        sclk[idx] = ~pol;
        mosi = mo_words[wi][bi];
        repeat (HALF) @(negedge clk);
        sclk[idx] = pol;
        mi_words[wi][bi] = miso[idx];
      end
    end
    repeat (HALF) @(negedge clk);
    if (raise_cs) begin
      cs[idx] = 1'b1;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (miso !== 5'b00000) begin n_fail++; $display("FAIL reset_miso got %b required 00000", miso); end
    n_checks++; if (tx_ready !== 5'b11111) begin n_fail++; $display("FAIL reset_tx_ready got %b required 11111", tx_ready); end
    n_checks++; if (rx_valid !== 5'b00000) begin n_fail++; $display("FAIL reset_rx_valid got %b required 00000", rx_valid); end
    n_checks++; if (busy !== 5'b00000) begin n_fail++; $display("FAIL reset_busy got %b required 00000", busy); end
    n_checks++; if (tx_underrun !== 5'b00000) begin n_fail++; $display("FAIL reset_underrun got %b required 00000", tx_underrun); end
    n_checks++; if (rx8 !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data8 got %h required 00", rx8); end
    n_checks++; if (rx16[3] !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data16 got %h required 0000", rx16[3]); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 5'b00000 || tx_ready !== 5'b11111) begin n_fail++; $display("FAIL post_reset_idle busy=%b tx_ready=%b required 00000/11111", busy, tx_ready); end
  endtask

  task automatic test_mode0_w8;
    int c0;
    c0 = rx_cnt[4];
    tx_push(4, 16'h00A5);
    n_checks++; if (tx_ready[4] !== 1'b0) begin n_fail++; $display("FAIL m0_tx_ready_fall got %b required 0", tx_ready[4]); end
    mo_words[0] = 16'h003C;
    spi_frame(4, 1, 0, 1);
    n_checks++; if (mi_words[0][7:0] !== 8'hA5) begin n_fail++; $display("FAIL m0_miso_bits got %h required a5", mi_words[0][7:0]); end
    n_checks++; if (rx_cnt[4] - c0 !== 1) begin n_fail++; $display("FAIL m0_rx_valid_count got %0d required 1", rx_cnt[4] - c0); end
    n_checks++; if (rx8 !== 8'h3C) begin n_fail++; $display("FAIL m0_rx_data got %h required 3c", rx8); end
    n_checks++; if (ur_cnt[4] !== 0) begin n_fail++; $display("FAIL m0_no_underrun got %0d required 0", ur_cnt[4]); end
    n_checks++; if (busy[4] !== 1'b0 || tx_ready[4] !== 1'b1) begin n_fail++; $display("FAIL m0_end_state busy=%b tx_ready=%b required 0/1", busy[4], tx_ready[4]); end
  endtask

  task automatic test_all_modes;
    int c0;
    for (int m = 0; m < 4; m++) begin
      c0 = rx_cnt[m];
      tx_push(m, 16'h1234);
      mo_words[0] = 16'hBEEF;
      spi_frame(m, 1, 0, 1);
      n_checks++; if (mi_words[0] !== 16'h1234) begin n_fail++; $display("FAIL mode%0d_miso got %h required 1234", m, mi_words[0]); end
      n_checks++; if (rx16[m] !== 16'hBEEF) begin n_fail++; $display("FAIL mode%0d_rx_data got %h required beef", m, rx16[m]); end
      n_checks++; if (rx_cnt[m] - c0 !== 1) begin n_fail++; $display("FAIL mode%0d_rx_count got %0d required 1", m, rx_cnt[m] - c0); end
      n_checks++; if (ur_cnt[m] !== 0) begin n_fail++; $display("FAIL mode%0d_underrun got %0d required 0", m, ur_cnt[m]); end
    end
  endtask

  task automatic test_back_to_back;
    int c0, u0;
    c0 = rx_cnt[4];
    u0 = ur_cnt[4];
    tx_push(4, 16'h0081);
    mo_words[0] = 16'h0011;
    mo_words[1] = 16'h0022;
    mo_words[2] = 16'h0033;
    fork
      begin
        tx_push(4, 16'h0082);
        tx_push(4, 16'h0083);
      end
      spi_frame(4, 3, 0, 1);
    join
    n_checks++; if (rx_cnt[4] - c0 !== 3) begin n_fail++; $display("FAIL b2b_rx_count got %0d required 3", rx_cnt[4] - c0); end
    n_checks++; if (rx_log[4][c0 % 8] !== 16'h0011) begin n_fail++; $display("FAIL b2b_rx_word0 got %h required 0011", rx_log[4][c0 % 8]); end
    n_checks++; if (rx_log[4][(c0 + 1) % 8] !== 16'h0022) begin n_fail++; $display("FAIL b2b_rx_word1 got %h required 0022", rx_log[4][(c0 + 1) % 8]); end
    n_checks++; if (rx_log[4][(c0 + 2) % 8] !== 16'h0033) begin n_fail++; $display("FAIL b2b_rx_word2 got %h required 0033", rx_log[4][(c0 + 2) % 8]); end
    n_checks++; if (mi_words[0][7:0] !== 8'h81 || mi_words[1][7:0] !== 8'h82 || mi_words[2][7:0] !== 8'h83) begin
      n_fail++; $display("FAIL b2b_miso got %h %h %h required 81 82 83", mi_words[0][7:0], mi_words[1][7:0], mi_words[2][7:0]);
    end
    n_checks++; if (ur_cnt[4] - u0 !== 0) begin n_fail++; $display("FAIL b2b_underrun got %0d required 0", ur_cnt[4] - u0); end
  endtask

  task automatic test_underrun;
    int c0, u0;
    c0 = rx_cnt[4];
    u0 = ur_cnt[4];
    tx_push(4, 16'h005C);
    mo_words[0] = 16'h0066;
    mo_words[1] = 16'h0099;
    spi_frame(4, 2, 0, 1);
    n_checks++; if (ur_cnt[4] - u0 !== 1) begin n_fail++; $display("FAIL ur_pulse_count got %0d required 1", ur_cnt[4] - u0); end
    n_checks++; if (mi_words[0][7:0] !== 8'h5C) begin n_fail++; $display("FAIL ur_miso_word0 got %h required 5c", mi_words[0][7:0]); end
    n_checks++; if (mi_words[1][7:0] !== 8'h00) begin n_fail++; $display("FAIL ur_miso_word1 got %h required 00", mi_words[1][7:0]); end
    n_checks++; if (rx_cnt[4] - c0 !== 2 || rx_log[4][c0 % 8] !== 16'h0066 || rx8 !== 8'h99) begin
      n_fail++; $display("FAIL ur_rx words=%0d first=%h last=%h required 2/0066/99", rx_cnt[4] - c0, rx_log[4][c0 % 8], rx8);
    end
  endtask

  task automatic test_cs_abort;
    int c0;
    c0 = rx_cnt[4];
    tx_push(4, 16'h00F0);
    mo_words[0] = 16'h00AA;
    spi_frame(4, 1, 5, 1);
    n_checks++; if (rx_cnt[4] - c0 !== 0) begin n_fail++; $display("FAIL abort_no_rx_valid got %0d required 0", rx_cnt[4] - c0); end
    n_checks++; if (rx8 !== 8'h99) begin n_fail++; $display("FAIL abort_rx_held got %h required 99", rx8); end
    n_checks++; if (miso[4] !== 1'b0 || busy[4] !== 1'b0) begin n_fail++; $display("FAIL abort_idle miso=%b busy=%b required 0/0", miso[4], busy[4]); end
    tx_push(4, 16'h00E7);
    mo_words[0] = 16'h005A;
    spi_frame(4, 1, 0, 1);
    n_checks++; if (rx8 !== 8'h5A || rx_cnt[4] - c0 !== 1) begin n_fail++; $display("FAIL abort_next_rx got %h/%0d required 5a/1", rx8, rx_cnt[4] - c0); end
    n_checks++; if (mi_words[0][7:0] !== 8'hE7) begin n_fail++; $display("FAIL abort_next_miso got %h required e7", mi_words[0][7:0]); end
  endtask

  task automatic test_reset_mid;
    int c0, u0;
    tx_push(4, 16'h0077);
    mo_words[0] = 16'h000F;
    spi_frame(4, 1, 4, 0);
    n_checks++; if (busy[4] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b required 1", busy[4]); end
    tx_push(4, 16'h0042);
    n_checks++; if (tx_ready[4] !== 1'b0) begin n_fail++; $display("FAIL rmid_buffer_full got %b required 0", tx_ready[4]); end
    rst = 1'b1;
    #1;
    n_checks++; if (miso[4] !== 1'b0 || tx_ready[4] !== 1'b1 || busy[4] !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reset_ctrl miso=%b tx_ready=%b busy=%b required 0/1/0", miso[4], tx_ready[4], busy[4]);
    end
    n_checks++; if (rx8 !== 8'h00 || rx_valid[4] !== 1'b0 || tx_underrun[4] !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reset_rx rx_data=%h rx_valid=%b tx_underrun=%b required 00/0/0", rx8, rx_valid[4], tx_underrun[4]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (busy[4] !== 1'b0) begin n_fail++; $display("FAIL rmid_cs_low_ignored busy=%b required 0", busy[4]); end
    cs[4] = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    c0 = rx_cnt[4];
    u0 = ur_cnt[4];
    tx_push(4, 16'h003D);
    mo_words[0] = 16'h00C3;
    spi_frame(4, 1, 0, 1);
    n_checks++; if (rx8 !== 8'hC3 || rx_cnt[4] - c0 !== 1) begin n_fail++; $display("FAIL rmid_next_rx got %h/%0d required c3/1", rx8, rx_cnt[4] - c0); end
    n_checks++; if (mi_words[0][7:0] !== 8'h3D) begin n_fail++; $display("FAIL rmid_next_miso got %h required 3d", mi_words[0][7:0]); end
    n_checks++; if (ur_cnt[4] - u0 !== 0) begin n_fail++; $display("FAIL rmid_underrun got %0d required 0", ur_cnt[4] - u0); end
  endtask

  initial begin
    test_reset();
    test_mode0_w8();
    test_all_modes();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
